// File: rtl/mult_result_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_result_fifo
//
// Captures results from an 8-stage pipelined multiplier (which cannot stall)
// into a DEPTH-entry FIFO and presents them on a valid/ready output. A credit
// scheme (issue_ok) bounds in-flight multiplies plus stored results to DEPTH,
// so every accepted issue owns a FIFO slot by the time its result returns.
//
// Optional feature macro: MULT_FIFO_STATS_EN (adds total_results, max_count).
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset (0 = in reset)
//   issue_in      issuer pulses this together with multiplier start
//   issue_ok      credit available; issuer may only pulse issue_in when 1
//   done          multiplier result strobe
//   product       multiplier result, sampled when done=1
//   out_valid     head entry valid
//   out_ready     consumer accepts head
//   out_data      head entry data (0 when empty)
//   count         entries stored
//   inflight      accepted issues whose done has not yet arrived
//   err           sticky protocol error (credit overrun, stray done, drop)
//   total_results successful enqueues, wrapping   (MULT_FIFO_STATS_EN only)
//   max_count     high-water mark of count        (MULT_FIFO_STATS_EN only)
//
// Output handshake: a transfer happens on a rising clock edge where
// out_valid and out_ready are both 1. out_valid/out_data depend only on
// registered state and never on out_ready; out_ready while empty is ignored.
// -----------------------------------------------------------------------------
module mult_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_in,
    output logic                     issue_ok,
    input  logic                     done,
    input  logic [WIDTH-1:0]         product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err
`ifdef MULT_FIFO_STATS_EN
    ,
    output logic [31:0]              total_results,
    output logic [$clog2(DEPTH):0]   max_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // One extra bit so count + inflight cannot overflow when err has let
    // them exceed DEPTH.
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    logic [CW:0]      occupancy;
    logic             full;
    logic             deq;
    logic             enq;
    logic             issue_acc;
    logic             ret_ok;
    logic             err_set;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    inflight_next;

    assign occupancy = {1'b0, count} + {1'b0, inflight};
    assign issue_ok  = (occupancy < DEPTH_X);
    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign deq       = out_valid & out_ready;
    // A full FIFO still accepts a result when the head leaves the same cycle.
    assign enq       = done & (~full | deq);
    assign issue_acc = issue_in & issue_ok;
    // A done with nothing outstanding does not decrement (saturates at 0).
    assign ret_ok    = done & (inflight != '0);

    assign err_set   = (issue_in & ~issue_ok)
                     | (done & (inflight == '0))
                     | (done & ~enq);

    always_comb begin
        count_next = count;
        if (enq && !deq) begin
            count_next = count + CW'(1);
        end else if (deq && !enq) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (issue_acc && !ret_ok) begin
            inflight_next = inflight + CW'(1);
        end else if (ret_ok && !issue_acc) begin
            inflight_next = inflight - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            inflight <= inflight_next;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is not reset: out_data is masked by out_valid while empty.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr] <= product;
        end
    end

`ifdef MULT_FIFO_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total_results <= '0;
            max_count     <= '0;
        end else begin
            if (enq) begin
                total_results <= total_results + 32'd1;
            end
            if (count_next > max_count) begin
                max_count <= count_next;
            end
        end
    end
`endif

endmodule
